// File: rtl/sync.sv
// Multi-stage synchronizer for a Gray-coded pointer crossing into clk_trg.
// Also gives the binary value of the synchronized pointer and flags any step that changes more than one bit.
module sync #(
  parameter int ADDR_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                  clk_trg,
  input  logic                  rst_trg,
  input  logic [ADDR_WIDTH-1:0] addr_src,
  output logic [ADDR_WIDTH-1:0] addr_trg,
  output logic [ADDR_WIDTH-1:0] addr_trg_bin,
  output logic                  gray_err
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] sync_reg1;
  logic [ADDR_WIDTH-1:0] sync_reg2;
  logic [ADDR_WIDTH-1:0] addr_prev_q;
  logic [ADDR_WIDTH-1:0] addr_diff;
  logic                  gray_err_d;
  logic                  gray_err_q;

  // addr_src feeds sync_reg1 directly, with no logic in front of the first flop.
  always_ff @(posedge clk_trg or posedge rst_trg) begin
    if (rst_trg) begin
      sync_reg1 <= '0;
      sync_reg2 <= '0;
    end else begin
      sync_reg1 <= addr_src;
      sync_reg2 <= sync_reg1;
    end
  end

  generate
    if (STAGES > 2) begin : g_tail
      localparam int NTAIL = STAGES - 2;
      logic [ADDR_WIDTH-1:0] tail_q [NTAIL];

      always_ff @(posedge clk_trg or posedge rst_trg) begin
        if (rst_trg) begin
          for (int i = 0; i < NTAIL; i++) tail_q[i] <= '0;
        end else begin
          tail_q[0] <= sync_reg2;
          for (int i = 1; i < NTAIL; i++) tail_q[i] <= tail_q[i-1];
        end
      end

      assign addr_trg = tail_q[NTAIL-1];
    end else begin : g_direct
      assign addr_trg = sync_reg2;
    end
  endgenerate

  // Binary bit i is the XOR of all Gray bits at position i and above.
  always_comb begin
    addr_trg_bin = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      addr_trg_bin[i] = ^(addr_trg >> i);
    end
  end

  // A set bit left over after clearing the lowest set bit means two or more bits changed.
  assign addr_diff  = addr_trg ^ addr_prev_q;
  assign gray_err_d = |(addr_diff & (addr_diff - ONE));

  always_ff @(posedge clk_trg or posedge rst_trg) begin
    if (rst_trg) begin
      addr_prev_q <= '0;
      gray_err_q  <= 1'b0;
    end else begin
      addr_prev_q <= addr_trg;
      gray_err_q  <= gray_err_d;
    end
  end

  assign gray_err = gray_err_q;

endmodule

// File: tb/tb_sync.sv
// Scoreboard bench for sync: stimulus pushes expected pointer values, a negedge monitor pops them when addr_trg changes.
module tb_sync;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  logic       clk_trg  = 1'b0;
  logic       clk_src  = 1'b0;
  logic       rst_trg  = 1'b0;
  logic [7:0] addr_src = 8'h00;
  logic [7:0] addr_trg;
  logic [7:0] addr_trg_bin;
  logic       gray_err;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         err_cnt  = 0;
  logic       seen_rst = 1'b0;
  logic [7:0] h1       = 8'h00;
  logic [7:0] h2       = 8'h00;
  logic [7:0] last_trg = 8'h00;

  always #7 clk_trg = ~clk_trg;
  always #5 clk_src = ~clk_src;

  sync #(.ADDR_WIDTH(8), .STAGES(2)) dut (
    .clk_trg      (clk_trg),
    .rst_trg      (rst_trg),
    .addr_src     (addr_src),
    .addr_trg     (addr_trg),
    .addr_trg_bin (addr_trg_bin),
    .gray_err     (gray_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic multibit(input logic [7:0] d);
    return (d & (d - 8'd1)) != 8'd0;
  endfunction

  task automatic push(input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    e.g = g;
    e.b = b;
    exp_q.push_back(e);
  endtask

  // Monitor: X watch, gray_err model from sampled history, scoreboard pop on every addr_trg change.
  always @(negedge clk_trg) begin
    exp_t e;
    if (seen_rst)
      check("x_free", {31'd0, $isunknown({dut.sync_reg1, dut.sync_reg2, addr_trg, gray_err})}, 32'd0);
    if (rst_trg) begin
      h1 = 8'h00;
      h2 = 8'h00;
      last_trg = 8'h00;
    end else if (seen_rst) begin
      check("gray_err", {31'd0, gray_err}, {31'd0, multibit(h1 ^ h2)});
      if (gray_err) err_cnt++;
      h2 = h1;
      h1 = addr_trg;
      if (addr_trg !== last_trg) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_addr_trg actual=%0h expected=no_change_from_%0h", addr_trg, last_trg);
        end else begin
          e = exp_q.pop_front();
          check("addr_trg", {24'd0, addr_trg}, {24'd0, e.g});
          check("addr_trg_bin", {24'd0, addr_trg_bin}, {24'd0, e.b});
        end
        last_trg = addr_trg;
      end
    end
  end

  initial begin
    logic [7:0] seq_g [4];
    logic [7:0] seq_b [4];
    seq_g = '{8'h03, 8'h02, 8'h06, 8'h07};
    seq_b = '{8'h02, 8'h03, 8'h04, 8'h05};

    // Reset values, no clock edge needed
    #1 rst_trg = 1'b1;
    seen_rst = 1'b1;
    #2;
    check("rst_sync_reg1", {24'd0, dut.sync_reg1}, 32'h0);
    check("rst_sync_reg2", {24'd0, dut.sync_reg2}, 32'h0);
    check("rst_addr_trg", {24'd0, addr_trg}, 32'h0);
    check("rst_addr_trg_bin", {24'd0, addr_trg_bin}, 32'h0);
    check("rst_gray_err", {31'd0, gray_err}, 32'h0);
    repeat (2) @(negedge clk_trg);
    #2 rst_trg = 1'b0;

    // Latency: captured at first edge, visible after second
    @(posedge clk_trg);
    #1 addr_src = 8'h01;
    push(8'h01, 8'h01);
    @(posedge clk_trg);
    #1;
    check("lat_sync_reg1", {24'd0, dut.sync_reg1}, 32'h01);
    check("lat_addr_trg_early", {24'd0, addr_trg}, 32'h00);
    @(posedge clk_trg);
    #1;
    check("lat_addr_trg", {24'd0, addr_trg}, 32'h01);

    // Gray count 2..5 from the source clock, held three source periods each
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_src);
      #1 addr_src = seq_g[i];
      push(seq_g[i], seq_b[i]);
      repeat (2) @(posedge clk_src);
    end
    repeat (4) @(posedge clk_src);

    // Change 2 ns before a target edge
    @(posedge clk_trg);
    #12 addr_src = 8'h05;
    push(8'h05, 8'h06);
    repeat (3) @(posedge clk_trg);
    #1;
    check("late_change_addr_trg", {24'd0, addr_trg}, 32'h05);

    // Wrap from Gray 255 to 0
    addr_src = 8'h80;
    push(8'h80, 8'hFF);
    #60;
    err_cnt = 0;
    addr_src = 8'h00;
    push(8'h00, 8'h00);
    #60;
    check("wrap_err_cnt", err_cnt, 32'd0);
    check("wrap_addr_trg", {24'd0, addr_trg}, 32'h00);

    // Two-bit jump must raise exactly one gray_err pulse
    err_cnt = 0;
    addr_src = 8'h03;
    push(8'h03, 8'h02);
    #60;
    check("jump_err_cnt", err_cnt, 32'd1);
    check("jump_addr_trg", {24'd0, addr_trg}, 32'h03);

    // Mid-stream reset discards the in-flight value
    @(posedge clk_trg);
    #1 addr_src = 8'h02;
    @(posedge clk_trg);
    #1;
    check("inflight_sync_reg1", {24'd0, dut.sync_reg1}, 32'h02);
    #2 rst_trg = 1'b1;
    addr_src = 8'h00;
    #1;
    check("mid_rst_sync_reg1", {24'd0, dut.sync_reg1}, 32'h0);
    check("mid_rst_sync_reg2", {24'd0, dut.sync_reg2}, 32'h0);
    check("mid_rst_addr_trg", {24'd0, addr_trg}, 32'h0);
    check("mid_rst_addr_trg_bin", {24'd0, addr_trg_bin}, 32'h0);
    check("mid_rst_gray_err", {31'd0, gray_err}, 32'h0);
    @(negedge clk_trg);
    #2 rst_trg = 1'b0;
    repeat (3) @(posedge clk_trg);
    #1;
    check("post_rst_addr_trg", {24'd0, addr_trg}, 32'h00);

    // Capture resumes after reset
    addr_src = 8'h01;
    push(8'h01, 8'h01);
    #60;
    check("resume_sync_reg2", {24'd0, dut.sync_reg2}, 32'h01);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync.md
SYNC -- requirements
Module: sync

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the width of the synchronized Gray-coded pointer.
REQ-002 Parameter STAGES, default 2, SHALL set the number of flip-flop stages; legal range 2..4.
REQ-003 clk_trg  input  1  target-domain clock; all state updates on its rising edge.
REQ-004 rst_trg  input  1  reset, asynchronous and active-high; one clock, no other reset.
REQ-005 addr_src  input  ADDR_WIDTH  Gray-coded pointer from the source domain, asynchronous to clk_trg.
REQ-006 addr_trg  output  ADDR_WIDTH  synchronized Gray pointer in the clk_trg domain.
REQ-007 addr_trg_bin  output  ADDR_WIDTH  binary conversion of addr_trg; may be left unconnected.
REQ-008 gray_err  output  1  registered flag, high for one cycle when addr_trg changes by more than one bit; may be left unconnected.

Function
REQ-009 The first stage register SHALL be named sync_reg1 and the second sync_reg2, both ADDR_WIDTH wide, accessible hierarchically.
REQ-010 On each rising clk_trg edge, sync_reg1 SHALL load addr_src and sync_reg2 SHALL load the prior sync_reg1.
REQ-011 For STAGES>2, further stages SHALL chain after sync_reg2 and addr_trg SHALL be driven by the last stage.
REQ-012 With STAGES=2, addr_trg SHALL equal sync_reg2 directly, with no combinational logic on the path.
REQ-013 Latency: a stable addr_src value sampled at edge N SHALL appear on addr_trg after edge N+STAGES-1 (two edges for STAGES=2).
REQ-014 addr_src SHALL pass through no logic before sync_reg1, which SHALL capture it directly.
REQ-015 If addr_src changes inside the setup/hold window of an edge, sync_reg1 may resolve to old or new value; addr_trg SHALL show either value, never X, and SHALL reach the new value within STAGES+1 edges.
REQ-016 addr_trg_bin SHALL be combinational Gray-to-binary of addr_trg: bit MSB = gray MSB; bit i = bin[i+1] XOR gray[i].
REQ-017 gray_err SHALL be registered: set high on the edge after addr_trg changes in more than one bit versus its previous value, otherwise low.
REQ-018 Wrap-around SHALL need no special handling: a one-bit Gray step from max to 0 propagates like any other value.

Reset
REQ-019 While rst_trg=1, all stages, addr_trg, addr_trg_bin and gray_err SHALL be 0 immediately, independent of clk_trg.
REQ-020 After rst_trg deasserts, the first rising edge SHALL resume normal capture; reset mid-operation SHALL discard in-flight values.
REQ-021 No register SHALL hold X after reset has been applied once.

Verification
REQ-022 rst_trg=1 with addr_src=8'h00 -> sync_reg1, sync_reg2, addr_trg = 8'h00, gray_err=0.
REQ-023 addr_src stepped through Gray(1..5) = 01,03,02,06,07, each held >=2 clk_trg periods (src 10 ns, trg 14 ns) -> addr_trg shows each value two trg edges after capture, in order; addr_trg_bin = 1..5.
REQ-024 addr_src changes to 05 (Gray 6) 2 ns before a trg edge -> addr_trg = 07 or 05, never X; 05 by the third following edge.
REQ-025 Continuous X monitor on sync_reg1/sync_reg2 after reset -> zero X reports for the whole run.
REQ-026 addr_src wraps 8'h80 (Gray 255) -> 8'h00 -> addr_trg follows; gray_err stays 0.
REQ-027 addr_src jumps 00 -> 03 (two-bit change) -> gray_err pulses high one cycle after addr_trg updates; asserting rst_trg mid-stream clears all outputs to 0 immediately.
